// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with mid-bit sampling, parity/framing/overrun flags
// and a ready/valid output that holds each word until the consumer takes it.
module uart_rx_os #(
    parameter int          NB_DATA    = 8,
    parameter logic [1:0]  PARITY     = 2'b00,
    parameter int          NB_STOP    = 1,
    parameter int          OVERSAMPLE = 16
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_rx,
    input  logic               i_tick,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_parity_err,
    output logic               o_frame_err,
    output logic               o_overrun
);
    localparam int SW = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t             state_q, state_d;
    logic               sync_q, rx_s_q;
    logic [SW-1:0]      s_cnt_q, s_cnt_d;
    logic [3:0]         n_cnt_q, n_cnt_d;
    logic [NB_DATA-1:0] shreg_q, shreg_d;
    logic               fpe_q, fpe_d, ffe_q, ffe_d;
    logic               armed_q, armed_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic               valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, ovr_q, ovr_d;
    logic               smp, done, hs;

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        shreg_d = shreg_q;
        fpe_d   = fpe_q;
        ffe_d   = ffe_q;
        armed_d = armed_q;
        done    = 1'b0;
        smp     = i_tick && s_cnt_q == SW'(OVERSAMPLE - 1);
        if (i_tick && state_q != IDLE)
            s_cnt_d = smp ? '0 : s_cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                // a fresh start needs a high level seen since the previous frame (break handling)
                if (rx_s_q) armed_d = 1'b1;
                else if (armed_q) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (i_tick && s_cnt_q == SW'(OVERSAMPLE / 2 - 1)) begin
                    state_d = rx_s_q ? IDLE : DATA;
                    s_cnt_d = '0;
                    n_cnt_d = '0;
                    fpe_d   = 1'b0;
                    ffe_d   = 1'b0;
                end
            end
            DATA: begin
                if (smp) begin
                    shreg_d = {rx_s_q, shreg_q[NB_DATA-1:1]};
                    n_cnt_d = n_cnt_q + 4'd1;
                    if (n_cnt_q == 4'(NB_DATA - 1)) begin
                        state_d = (PARITY != 2'b00) ? PAR : STOP;
                        n_cnt_d = '0;
                    end
                end
            end
            PAR: begin
                if (smp) begin
                    fpe_d   = ((^shreg_q) ^ rx_s_q) != PARITY[1];
                    state_d = STOP;
                    n_cnt_d = '0;
                end
            end
            STOP: begin
                if (smp) begin
                    ffe_d   = ffe_q | ~rx_s_q;
                    n_cnt_d = n_cnt_q + 4'd1;
                    if (n_cnt_q == 4'(NB_STOP - 1)) begin
                        done    = 1'b1;
                        state_d = IDLE;
                        armed_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hs      = valid_q & i_ready;
        valid_d = done | (valid_q & ~hs);
        data_d  = done ? shreg_q : data_q;
        pe_d    = done ? fpe_q : (hs ? 1'b0 : pe_q);
        fe_d    = done ? ffe_d : (hs ? 1'b0 : fe_q);
        ovr_d   = done ? (valid_q & ~i_ready) : (hs ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            sync_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            shreg_q <= '0;
            fpe_q   <= 1'b0;
            ffe_q   <= 1'b0;
            armed_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= i_rx;
            rx_s_q  <= sync_q;
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            shreg_q <= shreg_d;
            fpe_q   <= fpe_d;
            ffe_q   <= ffe_d;
            armed_q <= armed_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_parity_err = pe_q;
    assign o_frame_err  = fe_q;
    assign o_overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: randomized frames against a frame-level reference model (8 data, even parity,
// 2 stops); a scoreboard monitor pops expectations on every output handshake.
module tb_uart_rx_os;
    localparam int         NB  = 8;
    localparam int         OS  = 16;
    localparam logic [1:0] PAR = 2'b01;
    localparam int         NST = 2;

    logic          clk = 1'b0, i_rst_n = 1'b0, i_rx = 1'b1, i_tick = 1'b0, i_ready = 1'b1;
    logic [NB-1:0] o_data;
    logic          o_valid, o_parity_err, o_frame_err, o_overrun;

    typedef struct {
        logic [7:0] d;
        logic       pe, fe, ov;
    } exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0, tick_div = 1;

    uart_rx_os #(.NB_DATA(NB), .PARITY(PAR), .NB_STOP(NST), .OVERSAMPLE(OS)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_rx(i_rx), .i_tick(i_tick), .o_data(o_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_parity_err(o_parity_err),
        .o_frame_err(o_frame_err), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_wait();
        repeat (OS * tick_div) step();
    endtask

    // Reference: even parity is good when the parity bit equals the XOR of the data; any low stop is a frame error.
    task automatic push(input logic [7:0] d, input logic pbit, input logic [1:0] st, input logic ov);
        sb.push_back('{d, pbit != (^d), st != 2'b11, ov});
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic [1:0] st);
        i_rx = 1'b0;
        bit_wait();
        for (int i = 0; i < NB; i++) begin
            i_rx = d[i];
            bit_wait();
        end
        i_rx = pbit;
        bit_wait();
        for (int s = 0; s < NST; s++) begin
            i_rx = st[s];
            bit_wait();
        end
        i_rx = 1'b1;
    endtask

    initial begin
        int t = 0;
        forever begin
            step();
            t = (t + 1 >= tick_div) ? 0 : t + 1;
            i_tick = (t == 0);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_valid && i_ready) begin
                if (sb.size() == 0) chk("unexpected_valid", {24'd0, o_data}, 32'hFFFF_FFFF);
                else begin
                    e = sb.pop_front();
                    chk("data", o_data, e.d);
                    chk("parity_err", o_parity_err, e.pe);
                    chk("frame_err", o_frame_err, e.fe);
                    chk("overrun", o_overrun, e.ov);
                end
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic       pb;
        logic [1:0] st;
        int         n;
        repeat (3) step();
        @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_flags", {o_parity_err, o_frame_err, o_overrun}, 0);
        step();
        i_rst_n = 1'b1;
        repeat (20) step();
        // 0xA5 with correct parity; completion time from the falling edge
        push(8'hA5, 1'b0, 2'b11, 1'b0);
        fork
            send_frame(8'hA5, 1'b0, 2'b11);
            begin
                n = 0;
                while (!o_valid && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                chk("latency_in_window", (n >= 180 && n <= 196), 1);
            end
        join
        bit_wait();
        // parity good then bad
        push(8'h37, 1'b1, 2'b11, 1'b0);
        send_frame(8'h37, 1'b1, 2'b11);
        bit_wait();
        push(8'h37, 1'b0, 2'b11, 1'b0);
        send_frame(8'h37, 1'b0, 2'b11);
        bit_wait();
        // short low glitch must be dropped
        i_rx = 1'b0;
        repeat (4) step();
        i_rx = 1'b1;
        repeat (3 * OS) step();
        @(negedge clk);
        chk("glitch_no_valid", o_valid, 0);
        push(8'h3C, 1'b0, 2'b11, 1'b0);
        send_frame(8'h3C, 1'b0, 2'b11);
        bit_wait();
        // second stop bit low
        push(8'h81, 1'b0, 2'b01, 1'b0);
        send_frame(8'h81, 1'b0, 2'b01);
        bit_wait();
        // overrun: second word replaces the unaccepted first one
        i_ready = 1'b0;
        push(8'h11, 1'b0, 2'b11, 1'b0);
        send_frame(8'h11, 1'b0, 2'b11);
        void'(sb.pop_back());
        push(8'h22, 1'b0, 2'b11, 1'b1);
        send_frame(8'h22, 1'b0, 2'b11);
        repeat (10) step();
        @(negedge clk);
        chk("ovr_valid_held", o_valid, 1);
        chk("ovr_data", o_data, 8'h22);
        chk("ovr_flag", o_overrun, 1);
        step();
        i_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_hs_valid", o_valid, 0);
        chk("post_hs_overrun", o_overrun, 0);
        // reset during data bit 3; the rest of the frame is all ones so nothing restarts
        fork
            send_frame(8'hF8, 1'b1, 2'b11);
            begin
                repeat (4 * OS * tick_div + 8) step();
                i_rst_n = 1'b0;
                step();
                i_rst_n = 1'b1;
                @(negedge clk);
                chk("midrst_valid", o_valid, 0);
                chk("midrst_data", o_data, 0);
            end
        join
        bit_wait();
        push(8'h5A, 1'b0, 2'b11, 1'b0);
        send_frame(8'h5A, 1'b0, 2'b11);
        bit_wait();
        // break: completes once with frame error and does not restart while low
        push(8'h00, 1'b0, 2'b00, 1'b0);
        i_rx = 1'b0;
        repeat (14) bit_wait();
        i_rx = 1'b1;
        repeat (2) bit_wait();
        for (int k = 0; k < 30; k++) begin
            tick_div = $urandom_range(1, 3);
            d  = 8'($urandom);
            pb = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
            st = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
            push(d, pb, st, 1'b0);
            send_frame(d, pb, st);
            repeat ($urandom_range(1, 3)) bit_wait();
        end
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            step();
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
